// File: rtl/sa_cache_wb.sv
// N-way set-associative write-back / write-allocate cache with multi-word lines,
// tree pseudo-LRU replacement, burst write-back/refill and saturating hit/miss counters.
module sa_cache_wb #(
  parameter int WAYS       = 4,
  parameter int SETS       = 256,
  parameter int LINE_WORDS = 4,
  parameter int ADDR_W     = 32,
  parameter int DATA_W     = 32,
  parameter int CNT_W      = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [ADDR_W-1:0] mem_req_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_rsp_valid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic [CNT_W-1:0]  hit_count,
  output logic [CNT_W-1:0]  miss_count
);
  localparam int BYTE_W = $clog2(DATA_W/8);
  localparam int WSEL_W = $clog2(LINE_WORDS);
  localparam int OFF_W  = BYTE_W + WSEL_W;
  localparam int IDX_W  = $clog2(SETS);
  localparam int TAG_W  = ADDR_W - IDX_W - OFF_W;
  localparam int WAY_W  = $clog2(WAYS);
  localparam logic [WSEL_W-1:0] LAST_WORD = WSEL_W'(LINE_WORDS-1);

  typedef enum logic [2:0] {IDLE, LOOKUP, WB, RF_REQ, RF_DATA, RESP} state_t;

  typedef struct packed {
    logic              we;
    logic [TAG_W-1:0]  tag;
    logic [IDX_W-1:0]  idx;
    logic [WSEL_W-1:0] word;
    logic [DATA_W-1:0] wdata;
  } req_t;

  state_t            state;
  req_t              r;
  logic [WAY_W-1:0]  victim;
  logic [TAG_W-1:0]  victim_tag;
  logic [WSEL_W-1:0] beat, nxt_beat;

  logic [TAG_W-1:0]  tag_arr  [WAYS][SETS];
  logic [DATA_W-1:0] data_arr [WAYS][SETS][LINE_WORDS];
  logic [WAYS-1:0]   valid_arr [SETS];
  logic [WAYS-1:0]   dirty_arr [SETS];
  logic [WAYS-2:0]   plru_arr  [SETS];

  logic [WAYS-1:0]   hit_vec;
  logic              hit;
  logic [WAY_W-1:0]  hit_way, pick_way;
  logic              unused_addr;

  assign unused_addr = ^req_addr;
  assign nxt_beat    = beat + 1'b1;

  // Heap-ordered tree: node n has children 2n+1 / 2n+2; a 1 bit steers to the right child.
  function automatic logic [WAY_W-1:0] plru_victim(input logic [WAYS-2:0] t);
    int node;
    node = 0;
    for (int l = 0; l < WAY_W; l++) node = 2*node + 1 + (int'(t >> node) & 1);
    return WAY_W'(node - (WAYS-1));
  endfunction

  function automatic logic [WAYS-2:0] plru_touch(input logic [WAYS-2:0] t, input logic [WAY_W-1:0] way);
    logic [WAYS-2:0] res;
    int node, b;
    res  = t;
    node = 0;
    for (int l = 0; l < WAY_W; l++) begin
      b = (int'(way) >> (WAY_W-1-l)) & 1;
      if (b != 0) res = res & ~((WAYS-1)'(1) << node);
      else        res = res |  ((WAYS-1)'(1) << node);
      node = 2*node + 1 + b;
    end
    return res;
  endfunction

  function automatic logic [ADDR_W-1:0] word_addr(input logic [TAG_W-1:0] tag,
                                                 input logic [IDX_W-1:0] idx,
                                                 input logic [WSEL_W-1:0] word);
    return ADDR_W'({tag, idx, word}) << BYTE_W;
  endfunction

  for (genvar w = 0; w < WAYS; w++) begin : g_cmp
    assign hit_vec[w] = valid_arr[r.idx][w] && (tag_arr[w][r.idx] == r.tag);
  end
  assign hit = |hit_vec;

  // Victim: lowest invalid way first, otherwise the way the PLRU tree points at.
  always_comb begin
    logic found;
    hit_way  = '0;
    pick_way = plru_victim(plru_arr[r.idx]);
    found    = 1'b0;
    for (int w = 0; w < WAYS; w++) begin
      if (hit_vec[w]) hit_way = WAY_W'(w);
      if (!valid_arr[r.idx][w] && !found) begin
        pick_way = WAY_W'(w);
        found    = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      r             <= '0;
      victim        <= '0;
      victim_tag    <= '0;
      beat          <= '0;
      req_ready     <= 1'b1;
      rsp_valid     <= 1'b0;
      rsp_rdata     <= '0;
      mem_req_valid <= 1'b0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_wdata     <= '0;
      hit_count     <= '0;
      miss_count    <= '0;
      for (int s = 0; s < SETS; s++) begin
        valid_arr[s] <= '0;
        dirty_arr[s] <= '0;
        plru_arr[s]  <= '0;
      end
    end else begin
      case (state)
        IDLE: begin
          if (req_valid) begin
            r.we      <= req_we;
            r.tag     <= req_addr[ADDR_W-1 -: TAG_W];
            r.idx     <= req_addr[OFF_W +: IDX_W];
            r.word    <= req_addr[BYTE_W +: WSEL_W];
            r.wdata   <= req_wdata;
            req_ready <= 1'b0;
            state     <= LOOKUP;
          end
        end
        LOOKUP: begin
          if (hit) begin
            if (r.we) begin
              data_arr[hit_way][r.idx][r.word] <= r.wdata;
              dirty_arr[r.idx][hit_way]        <= 1'b1;
              rsp_rdata                        <= '0;
            end else begin
              rsp_rdata <= data_arr[hit_way][r.idx][r.word];
            end
            plru_arr[r.idx] <= plru_touch(plru_arr[r.idx], hit_way);
            if (~&hit_count) hit_count <= hit_count + 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            if (~&miss_count) miss_count <= miss_count + 1'b1;
            victim        <= pick_way;
            victim_tag    <= tag_arr[pick_way][r.idx];
            beat          <= '0;
            mem_req_valid <= 1'b1;
            if (valid_arr[r.idx][pick_way] && dirty_arr[r.idx][pick_way]) begin
              mem_req_we   <= 1'b1;
              mem_req_addr <= word_addr(tag_arr[pick_way][r.idx], r.idx, '0);
              mem_wdata    <= data_arr[pick_way][r.idx][0];
              state        <= WB;
            end else begin
              mem_req_we   <= 1'b0;
              mem_req_addr <= word_addr(r.tag, r.idx, '0);
              state        <= RF_REQ;
            end
          end
        end
        WB: begin
          if (mem_req_ready) begin
            if (beat == LAST_WORD) begin
              mem_req_we   <= 1'b0;
              mem_req_addr <= word_addr(r.tag, r.idx, '0);
              mem_wdata    <= '0;
              state        <= RF_REQ;
            end else begin
              beat         <= nxt_beat;
              mem_req_addr <= word_addr(victim_tag, r.idx, nxt_beat);
              mem_wdata    <= data_arr[victim][r.idx][nxt_beat];
            end
          end
        end
        RF_REQ: begin
          if (mem_req_ready) begin
            mem_req_valid <= 1'b0;
            beat          <= '0;
            state         <= RF_DATA;
          end
        end
        RF_DATA: begin
          if (mem_rsp_valid) begin
            data_arr[victim][r.idx][beat] <= mem_rdata;
            beat <= nxt_beat;
            if (beat == LAST_WORD) begin
              // Fill and access retire together; the store merge overrides the beat write.
              tag_arr[victim][r.idx]   <= r.tag;
              valid_arr[r.idx][victim] <= 1'b1;
              dirty_arr[r.idx][victim] <= r.we;
              if (r.we) begin
                data_arr[victim][r.idx][r.word] <= r.wdata;
                rsp_rdata <= '0;
              end else begin
                rsp_rdata <= (r.word == beat) ? mem_rdata : data_arr[victim][r.idx][r.word];
              end
              plru_arr[r.idx] <= plru_touch(plru_arr[r.idx], victim);
              rsp_valid       <= 1'b1;
              state           <= RESP;
            end
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          rsp_rdata <= '0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_sa_cache_wb.sv
// Directed bench for sa_cache_wb: scoreboarded core responses and memory requests,
// a behavioural memory with stall / refill-pause controls, and a CNT_W=4 twin for saturation.
module tb_sa_cache_wb;
  localparam int LW = 4;

  logic        clk = 1'b0, rst = 1'b1;
  logic        req_valid = 1'b0, req_we = 1'b0;
  logic [31:0] req_addr = '0, req_wdata = '0;
  logic        mem_req_ready = 1'b0, mem_rsp_valid = 1'b0;
  logic [31:0] mem_rdata = '0;

  logic        req_ready, rsp_valid, mem_req_valid, mem_req_we;
  logic [31:0] rsp_rdata, mem_req_addr, mem_wdata, hit_count, miss_count;

  logic        req_ready4, rsp_valid4, mem_req_valid4, mem_req_we4;
  logic [31:0] rsp_rdata4, mem_req_addr4, mem_wdata4;
  logic [3:0]  hit_count4, miss_count4;

  sa_cache_wb dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we),
    .mem_req_addr(mem_req_addr), .mem_wdata(mem_wdata), .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata(mem_rdata), .hit_count(hit_count), .miss_count(miss_count));

  // Same stimulus as dut, so it sees identical traffic; only the counter width differs.
  sa_cache_wb #(.CNT_W(4)) dut4 (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready4), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid4), .rsp_rdata(rsp_rdata4),
    .mem_req_valid(mem_req_valid4), .mem_req_ready(mem_req_ready), .mem_req_we(mem_req_we4),
    .mem_req_addr(mem_req_addr4), .mem_wdata(mem_wdata4), .mem_rsp_valid(mem_rsp_valid),
    .mem_rdata(mem_rdata), .hit_count(hit_count4), .miss_count(miss_count4));

  initial forever #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
  } mreq_t;

  mreq_t       exp_mem_q[$];
  logic [31:0] exp_rsp_q[$];
  logic [31:0] mem_model [logic [31:0]];
  int n_assert = 0, n_fail = 0;
  int exp_hits = 0, exp_miss = 0;
  int stall_w = 0, stall_r = 0, rf_limit = 1000;
  bit rf_paused = 1'b0;
  int cyc = 0, acc_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [95:0] obs, input logic [95:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] dflt(input logic [31:0] a);
    return {16'hC0DE, a[15:0]};
  endfunction

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    return mem_model.exists(a) ? mem_model[a] : dflt(a);
  endfunction

  task automatic exp_rd(input logic [31:0] a);
    mreq_t m;
    m.we = 1'b0; m.addr = a; m.data = '0;
    exp_mem_q.push_back(m);
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d);
    mreq_t m;
    m.we = 1'b1; m.addr = a; m.data = d;
    exp_mem_q.push_back(m);
  endtask

  // Memory model: everything happens on the negedge, so the DUT samples it at the next posedge.
  initial begin : mem_side
    int beats_left, rf_given;
    logic [31:0] rf_addr;
    logic [64:0] snap;
    bit stall_active;
    mreq_t m;
    beats_left = 0; rf_given = 0; rf_addr = '0; snap = '0; stall_active = 1'b0;
    forever begin
      @(negedge clk);
      if (rst) begin
        beats_left = 0; rf_paused = 1'b0; stall_active = 1'b0;
        mem_req_ready = 1'b0; mem_rsp_valid = 1'b0;
      end else begin
        mem_rsp_valid = 1'b0;
        if (beats_left > 0) begin
          if (rf_given >= rf_limit) rf_paused = 1'b1;
          else begin
            mem_rsp_valid = 1'b1;
            mem_rdata     = mem_rd(rf_addr + 32'(4 * (LW - beats_left)));
            beats_left--;
            rf_given++;
          end
        end
        mem_req_ready = 1'b0;
        if (stall_active) check("mem_req_valid held", 96'(mem_req_valid), 96'(1));
        if (mem_req_valid) begin
          if ((mem_req_we && stall_w > 0) || (!mem_req_we && stall_r > 0)) begin
            if (!stall_active) begin
              snap = {mem_req_we, mem_req_addr, mem_wdata};
              stall_active = 1'b1;
            end else check("stalled req stable", 96'({mem_req_we, mem_req_addr, mem_wdata}), 96'(snap));
            if (mem_req_we) stall_w--; else stall_r--;
          end else begin
            if (stall_active) begin
              check("stalled req stable", 96'({mem_req_we, mem_req_addr, mem_wdata}), 96'(snap));
              stall_active = 1'b0;
            end
            mem_req_ready = 1'b1;
            check("mem req queued", 96'(exp_mem_q.size() != 0), 96'(1));
            if (exp_mem_q.size() != 0) begin
              m = exp_mem_q.pop_front();
              check("mem req", {31'd0, mem_req_we, mem_req_addr, mem_req_we ? mem_wdata : 32'd0},
                    {31'd0, m.we, m.addr, m.data});
            end
            if (mem_req_we) mem_model[mem_req_addr] = mem_wdata;
            else begin
              beats_left = LW; rf_given = 0; rf_addr = mem_req_addr;
            end
          end
        end
      end
    end
  end

  task automatic access(input string tag, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp_rdata, input bit exp_hit);
    int n, lat;
    logic [31:0] e;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    check({tag, " req_ready"}, 96'(req_ready), 96'(1));
    req_valid = 1'b1; req_we = we; req_addr = addr; req_wdata = wdata;
    exp_rsp_q.push_back(exp_rdata);
    if (exp_hit) exp_hits++; else exp_miss++;
    @(negedge clk);
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0;
    acc_cyc = cyc;
    lat = 1;
    while (!rsp_valid && lat < 300) begin @(negedge clk); lat++; end
    check({tag, " rsp_valid"}, 96'(rsp_valid), 96'(1));
    if (rsp_valid && exp_rsp_q.size() != 0) begin
      e = exp_rsp_q.pop_front();
      check({tag, " rdata"}, 96'(rsp_rdata), 96'(e));
    end
    if (exp_hit) check({tag, " hit latency"}, 96'(lat), 96'(2));
    check({tag, " hit_count"}, 96'(hit_count), 96'(exp_hits));
    check({tag, " miss_count"}, 96'(miss_count), 96'(exp_miss));
    check({tag, " mem reqs outstanding"}, 96'(exp_mem_q.size()), 96'(0));
    @(negedge clk);
    check({tag, " rsp one cycle"}, 96'(rsp_valid), 96'(0));
  endtask

  task automatic do_reset();
    rst = 1'b1;
    exp_mem_q.delete(); exp_rsp_q.delete();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_hits = 0; exp_miss = 0; stall_w = 0; stall_r = 0; rf_limit = 1000;
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin : main
    int n, prev;
    for (int i = 0; i < LW; i++) mem_model[32'h100 + 32'(4*i)] = 32'hA0 + 32'(i);

    // Reset state
    repeat (2) @(negedge clk);
    check("reset req_ready", 96'(req_ready), 96'(1));
    check("reset outputs", 96'({rsp_valid, rsp_rdata, mem_req_valid, mem_req_we, mem_req_addr}), 96'(0));
    check("reset counters", 96'({hit_count, miss_count}), 96'(0));
    rst = 1'b0;

    // 1: cold miss then hit in the same line
    exp_rd(32'h100);
    access("t1 miss", 1'b0, 32'h104, 32'h0, 32'hA1, 1'b0);
    access("t1 hit", 1'b0, 32'h108, 32'h0, 32'hA2, 1'b1);

    // 2: dirty way 0 filled first, then ways 1..3; the PLRU tree now points at way 0
    do_reset();
    exp_rd(32'h100);
    access("t2 st", 1'b1, 32'h100, 32'hDEADBEEF, 32'h0, 1'b0);
    for (int t = 1; t < 4; t++) begin
      exp_rd(32'h100 + 32'(t * 32'h1000));
      access("t2 fill", 1'b0, 32'h100 + 32'(t * 32'h1000), 32'h0, dflt(32'h100 + 32'(t * 32'h1000)), 1'b0);
    end
    exp_wr(32'h100, 32'hDEADBEEF); exp_wr(32'h104, 32'hA1);
    exp_wr(32'h108, 32'hA2);       exp_wr(32'h10C, 32'hA3);
    exp_rd(32'h4100);
    access("t2 evict", 1'b0, 32'h4100, 32'h0, dflt(32'h4100), 1'b0);
    // way 2 is the next PLRU choice and is clean: plain refill, written-back data comes back
    exp_rd(32'h100);
    access("t2 reload", 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1'b0);
    access("t2 way1 hit", 1'b0, 32'h1104, 32'h0, dflt(32'h1104), 1'b1);

    // 3: store miss allocates a dirty line
    do_reset();
    exp_rd(32'h200);
    access("t3 st", 1'b1, 32'h208, 32'h12345678, 32'h0, 1'b0);
    access("t3 ld", 1'b0, 32'h208, 32'h0, 32'h12345678, 1'b1);
    for (int t = 1; t < 4; t++) begin
      exp_rd(32'h200 + 32'(t * 32'h1000));
      access("t3 fill", 1'b0, 32'h200 + 32'(t * 32'h1000), 32'h0, dflt(32'h200 + 32'(t * 32'h1000)), 1'b0);
    end
    exp_wr(32'h200, dflt(32'h200)); exp_wr(32'h204, dflt(32'h204));
    exp_wr(32'h208, 32'h12345678);  exp_wr(32'h20C, dflt(32'h20C));
    exp_rd(32'h4200);
    access("t3 evict", 1'b0, 32'h4200, 32'h0, dflt(32'h4200), 1'b0);

    // 4: back-pressure on write-back and on the refill request
    do_reset();
    exp_rd(32'h300);
    access("t4 st", 1'b1, 32'h300, 32'hCAFEF00D, 32'h0, 1'b0);
    for (int t = 1; t < 4; t++) begin
      exp_rd(32'h300 + 32'(t * 32'h1000));
      access("t4 fill", 1'b0, 32'h300 + 32'(t * 32'h1000), 32'h0, dflt(32'h300 + 32'(t * 32'h1000)), 1'b0);
    end
    stall_w = 5; stall_r = 5;
    exp_wr(32'h300, 32'hCAFEF00D); exp_wr(32'h304, dflt(32'h304));
    exp_wr(32'h308, dflt(32'h308)); exp_wr(32'h30C, dflt(32'h30C));
    exp_rd(32'h4300);
    access("t4 evict", 1'b0, 32'h4304, 32'h0, dflt(32'h4304), 1'b0);
    check("t4 stalls consumed", 96'(stall_w + stall_r), 96'(0));

    // 5: reset in the middle of a refill
    do_reset();
    rf_limit = 2;
    exp_rd(32'h500);
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    req_valid = 1'b1; req_addr = 32'h500;
    @(negedge clk);
    req_valid = 1'b0; req_addr = '0;
    n = 0;
    while (!rf_paused && n < 100) begin @(negedge clk); n++; end
    check("t5 refill paused", 96'(rf_paused), 96'(1));
    rst = 1'b1;
    @(negedge clk);
    check("t5 req_ready", 96'(req_ready), 96'(1));
    check("t5 rsp/mem idle", 96'({rsp_valid, mem_req_valid}), 96'(0));
    check("t5 counters", 96'({hit_count, miss_count}), 96'(0));
    @(negedge clk);
    rst = 1'b0;
    exp_mem_q.delete(); exp_hits = 0; exp_miss = 0; rf_limit = 1000;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("t5 no stray rsp", 96'({rsp_valid, mem_req_valid}), 96'(0));
    end
    exp_rd(32'h500);
    access("t5 re-miss", 1'b0, 32'h500, 32'h0, dflt(32'h500), 1'b0);

    // 6: 20 back-to-back hits, 3-cycle issue rate, 4-bit counter saturates
    prev = 0;
    for (int i = 0; i < 20; i++) begin
      access("t6 hit", 1'b0, 32'h504, 32'h0, dflt(32'h504), 1'b1);
      if (i > 0) check("t6 issue spacing", 96'(acc_cyc - prev), 96'(3));
      prev = acc_cyc;
      if (i == 13) check("t6 cnt4 pre-sat", 96'(hit_count4), 96'(14));
    end
    check("t6 cnt4 hit sat", 96'(hit_count4), 96'(4'hF));
    check("t6 cnt4 miss", 96'(miss_count4), 96'(1));

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
